// File: rtl/mem_pkg.sv
// Shared store-path types: size encodings, the buffered store entry and the legality rule.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package mem_pkg;

    // Default byte-address width of the data memory port
    localparam int MEM_ADDR_W = 32;

    // Store access size as carried by the MEM stage
    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_e;

    // One buffered store: word address, lane-positioned data, byte enables
    typedef struct packed {
        logic [MEM_ADDR_W-1:2] addr;
        logic [31:0]           data;
        logic [3:0]            be;
    } st_entry_t;

    // A store is legal when its size is defined and its address is naturally aligned
    function automatic logic store_is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Narrows a register value to byte/half/word lanes and builds byte enables and legality.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is enqueued.
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic [3:0]  o_be,
    output logic        o_legal
);

    // Replicate the narrow value into every lane and pick the enabled lanes by address
    always_comb begin
        o_data  = i_data;
        o_be    = 4'b0000;
        o_legal = store_is_legal(i_size, i_addr_lo);
        case (i_size)
            SZ_BYTE: begin
                o_data = {4{i_data[7:0]}};
                o_be   = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_data = {2{i_data[15:0]}};
                o_be   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                o_be   = 4'b1111;
            end
            default: begin
                o_be   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buffer.sv
// In-order store write buffer: narrows MEM-stage stores, queues them, drains over req/ack.
// Latency: a store accepted at edge N can drive MemReq from cycle N+1; one drain per cycle sustained.
// Backpressure: StallOut when full without a same-cycle pop, or when a load hits a pending word.
module store_narrow_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StoreValid,
    input  logic [1:0]        StoreSize,
    input  logic [ADDR_W-1:0] StoreAddr,
    input  logic [31:0]       StoreData,
    input  logic              LoadValid,
    input  logic [ADDR_W-1:0] LoadAddr,
    output logic              StallOut,
    output logic              MisalignErr,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemBE,
    input  logic              MemAck,
    output logic              Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same layout as mem_pkg::st_entry_t, sized by this instance's ADDR_W
    typedef struct packed {
        logic [ADDR_W-1:2] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_e;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    drain_state_e      r_state;
    logic [ADDR_W-1:2] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_misalign;

    drain_state_e      w_state_nxt;
    logic [31:0]       w_lane_data;
    logic [3:0]        w_lane_be;
    logic              w_legal;
    entry_t            w_new;
    entry_t            w_head;
    logic              w_full;
    logic              w_pop;
    logic              w_enq;
    logic [CNT_W-1:0]  w_remain;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [PTR_W-1:0]  w_head_idx;
    logic              w_load_head;
    logic [DEPTH-1:0]  w_hit;
    logic              w_load_hit;
    logic              w_unused_load_lo;

    store_lane_align u_align (
        .i_size    (StoreSize),
        .i_addr_lo (StoreAddr[1:0]),
        .i_data    (StoreData),
        .o_data    (w_lane_data),
        .o_be      (w_lane_be),
        .o_legal   (w_legal)
    );

    assign w_new = '{addr: StoreAddr[ADDR_W-1:2], data: w_lane_data, be: w_lane_be};

    // Loads compare at word granularity, so the byte offset is deliberately ignored
    assign w_unused_load_lo = &{1'b0, LoadAddr[1:0]};

    assign MemReq   = (r_state == ST_REQ);
    assign w_pop    = MemReq & MemAck;
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_enq    = StoreValid & w_legal & (~w_full | w_pop);

    // Occupancy after the pop only, then after the push as well
    assign w_remain    = r_count - CNT_W'(w_pop);
    assign w_count_nxt = w_remain + CNT_W'(w_enq);

    // Next head: the slot after the popped one, or the incoming store when nothing else is left
    assign w_head_idx = r_rd_ptr + PTR_W'(w_pop);
    assign w_head     = (w_remain == '0) ? w_new : r_mem[w_head_idx];

    // Flag every live entry whose word address matches the load
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = (CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) &&
                       (r_mem[i].addr == LoadAddr[ADDR_W-1:2]);
        end
    end

    assign w_load_hit = LoadValid & (|w_hit);
    assign StallOut   = (StoreValid & w_full & ~w_pop) | w_load_hit;
    assign Empty      = (r_count == '0) & ~MemReq;

    assign MemAddr     = {r_mem_addr, 2'b00};
    assign MemWData    = r_mem_wdata;
    assign MemBE       = r_mem_be;
    assign MisalignErr = r_misalign;

    // Entry storage; occupancy is tracked by the pointers so no reset is needed here
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // Pointers and occupancy; both pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state: request while anything is queued after this cycle's pop/push
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_count_nxt != '0)          w_state_nxt = ST_REQ;
            ST_REQ:  if (w_pop && w_count_nxt == '0) w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Drain FSM outputs: reload the request registers on start-up or after an accepted head
    always_comb begin
        w_load_head = 1'b0;
        case (r_state)
            ST_IDLE: w_load_head = (w_count_nxt != '0);
            ST_REQ:  w_load_head = w_pop && (w_count_nxt != '0);
            default: w_load_head = 1'b0;
        endcase
    end

    // Request payload stays stable until acknowledged; misalignment is reported one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_mem_addr  <= w_head.addr;
                r_mem_wdata <= w_head.data;
                r_mem_be    <= w_head.be;
            end
            r_misalign <= StoreValid & ~w_legal;
        end
    end

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed-vector bench for the store narrowing write buffer.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: MemAck is driven by the bench to exercise stall and drain paths.
module tb_store_narrow_buffer;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        StoreValid;
    logic [1:0]  StoreSize;
    logic [31:0] StoreAddr;
    logic [31:0] StoreData;
    logic        LoadValid;
    logic [31:0] LoadAddr;
    logic        StallOut;
    logic        MisalignErr;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic        MemAck;
    logic        Empty;

    int n_chk  = 0;
    int n_fail = 0;

    store_narrow_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .StoreValid  (StoreValid),
        .StoreSize   (StoreSize),
        .StoreAddr   (StoreAddr),
        .StoreData   (StoreData),
        .LoadValid   (LoadValid),
        .LoadAddr    (LoadAddr),
        .StallOut    (StallOut),
        .MisalignErr (MisalignErr),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemBE       (MemBE),
        .MemAck      (MemAck),
        .Empty       (Empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        StoreValid = 1'b0;
        LoadValid  = 1'b0;
        MemAck     = 1'b0;
    endtask

    task automatic put_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        StoreValid = 1'b1;
        StoreSize  = sz;
        StoreAddr  = a;
        StoreData  = d;
    endtask

    initial begin
        reset     = 1'b1;
        StoreSize = 2'b00;
        StoreAddr = '0;
        StoreData = '0;
        LoadAddr  = '0;
        idle_inputs();
        repeat (2) tick();

        // Reset state
        sample();
        check("rst_req",      MemReq,      0);
        check("rst_empty",    Empty,       1);
        check("rst_stall",    StallOut,    0);
        check("rst_misalign", MisalignErr, 0);
        check("rst_addr",     MemAddr,     0);
        check("rst_wdata",    MemWData,    0);
        check("rst_be",       MemBE,       0);
        tick();
        reset = 1'b0;

        // Byte store at 0x1003
        tick();
        put_store(SB, 32'h0000_1003, 32'h1234_5678);
        sample();
        check("sb_nostall", StallOut, 0);
        tick();
        idle_inputs();
        MemAck = 1'b1;
        sample();
        check("sb_req",   MemReq,   1);
        check("sb_addr",  MemAddr,  32'h0000_1000);
        check("sb_wdata", MemWData, 32'h7878_7878);
        check("sb_be",    MemBE,    4'b1000);
        check("sb_busy",  Empty,    0);
        tick();
        idle_inputs();
        sample();
        check("sb_req_drop", MemReq, 0);
        check("sb_empty",    Empty,  1);

        // Halfword store, then misaligned and illegal stores
        tick();
        put_store(SH, 32'h0000_2002, 32'hAAAA_BEEF);
        tick();
        idle_inputs();
        MemAck = 1'b1;
        sample();
        check("sh_addr",  MemAddr,  32'h0000_2000);
        check("sh_wdata", MemWData, 32'hBEEF_BEEF);
        check("sh_be",    MemBE,    4'b1100);
        tick();
        idle_inputs();
        put_store(SH, 32'h0000_2001, 32'h0000_1234);
        sample();
        check("sh_mis_nostall", StallOut, 0);
        tick();
        idle_inputs();
        sample();
        check("sh_mis_pulse", MisalignErr, 1);
        check("sh_mis_noreq", MemReq,      0);
        check("sh_mis_empty", Empty,       1);
        tick();
        put_store(SX, 32'h0000_2000, 32'h0);
        sample();
        check("mis_pulse_end", MisalignErr, 0);
        tick();
        put_store(SW, 32'h0000_2002, 32'h0);
        sample();
        check("sz11_pulse", MisalignErr, 1);
        tick();
        idle_inputs();
        sample();
        check("sw_mis_pulse", MisalignErr, 1);
        check("sw_mis_empty", Empty,       1);
        tick();
        sample();
        check("mis_quiet", MisalignErr, 0);

        // Five words into a four-entry buffer with MemAck low
        for (int i = 1; i <= 4; i++) begin
            tick();
            put_store(SW, 32'h0000_4000 + 32'(4 * (i - 1)), 32'h1000_0000 + 32'(i));
            sample();
            check("fill_nostall", StallOut, 0);
        end
        tick();
        put_store(SW, 32'h0000_4010, 32'h1000_0005);
        sample();
        check("full_stall", StallOut, 1);
        tick();
        MemAck = 1'b1;
        sample();
        check("full_pop_nostall", StallOut, 0);
        check("drain_addr1",      MemAddr,  32'h0000_4000);
        check("drain_data1",      MemWData, 32'h1000_0001);
        tick();
        StoreValid = 1'b0;
        MemAck     = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            sample();
            check("drain_req",  MemReq,   1);
            check("drain_addr", MemAddr,  32'h0000_4000 + 32'(4 * (i - 1)));
            check("drain_data", MemWData, 32'h1000_0000 + 32'(i));
            tick();
        end
        MemAck = 1'b0;
        sample();
        check("drain_done_req",   MemReq, 0);
        check("drain_done_empty", Empty,  1);

        // Load hazard against a pending word
        tick();
        put_store(SW, 32'h0000_3000, 32'h55AA_55AA);
        tick();
        idle_inputs();
        LoadValid = 1'b1;
        LoadAddr  = 32'h0000_3002;
        sample();
        check("ld_hit_stall", StallOut, 1);
        check("ld_hit_req",   MemReq,   1);
        tick();
        LoadAddr = 32'h0000_3004;
        sample();
        check("ld_miss_nostall", StallOut, 0);
        tick();
        LoadAddr = 32'h0000_3002;
        sample();
        check("ld_hit_hold", StallOut, 1);
        tick();
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        sample();
        check("ld_after_ack", StallOut, 0);
        check("ld_after_empty", Empty,  1);
        tick();
        idle_inputs();

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            put_store(SW, 32'h0000_5000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
            tick();
        end
        idle_inputs();
        sample();
        check("mid_req", MemReq, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample();
        check("mid_rst_req",   MemReq,  0);
        check("mid_rst_empty", Empty,   1);
        check("mid_rst_addr",  MemAddr, 0);
        MemAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("post_rst_noreq", MemReq, 0);
            check("post_rst_empty", Empty,  1);
        end
        MemAck = 1'b0;

        // One store and one ack every cycle, wrapping the pointers past the depth
        for (int k = 0; k < 10; k++) begin
            tick();
            put_store(SW, 32'h0000_6000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            MemAck = (k > 0);
            sample();
            check("tp_nostall", StallOut, 0);
            if (k > 0) begin
                check("tp_req",  MemReq,   1);
                check("tp_addr", MemAddr,  32'h0000_6000 + 32'(4 * (k - 1)));
                check("tp_data", MemWData, 32'hC0DE_0000 + 32'(k - 1));
            end
        end
        tick();
        StoreValid = 1'b0;
        MemAck     = 1'b1;
        sample();
        check("tp_last_req",  MemReq,   1);
        check("tp_last_addr", MemAddr,  32'h0000_6024);
        check("tp_last_data", MemWData, 32'hC0DE_0009);
        tick();
        MemAck = 1'b0;
        sample();
        check("tp_end_req",   MemReq, 0);
        check("tp_end_empty", Empty,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
